reservation_station: RTL

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/reservation_station.sv
// Reservation station: DEPTH-entry operand buffer with dual dispatch, dual CDB wakeup
// and a one-deep registered issue output.
module reservation_station #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rs_valid_1,
  input  logic [3:0]  rs_opcode_1,
  input  logic [2:0]  rs_alu_op_1,
  input  logic [4:0]  rs_tag_a_1,
  input  logic [4:0]  rs_tag_b_1,
  input  logic [15:0] rs_data_a_1,
  input  logic [15:0] rs_data_b_1,
  input  logic        rs_valid_a_1,
  input  logic        rs_valid_b_1,
  input  logic [15:0] rs_imm_1,
  input  logic [15:0] rs_pc_1,
  input  logic [4:0]  rs_rrf_dest_1,
  input  logic        rs_valid_2,
  input  logic [3:0]  rs_opcode_2,
  input  logic [2:0]  rs_alu_op_2,
  input  logic [4:0]  rs_tag_a_2,
  input  logic [4:0]  rs_tag_b_2,
  input  logic [15:0] rs_data_a_2,
  input  logic [15:0] rs_data_b_2,
  input  logic        rs_valid_a_2,
  input  logic        rs_valid_b_2,
  input  logic [15:0] rs_imm_2,
  input  logic [15:0] rs_pc_2,
  input  logic [4:0]  rs_rrf_dest_2,
  input  logic        cdb_valid_1,
  input  logic [4:0]  cdb_tag_1,
  input  logic [15:0] cdb_data_1,
  input  logic        cdb_valid_2,
  input  logic [4:0]  cdb_tag_2,
  input  logic [15:0] cdb_data_2,
  input  logic        flush,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [3:0]  issue_opcode,
  output logic [2:0]  issue_alu_op,
  output logic [15:0] issue_data_a,
  output logic [15:0] issue_data_b,
  output logic [15:0] issue_imm,
  output logic [15:0] issue_pc,
  output logic [4:0]  issue_rrf_dest,
  output logic        rs_full,
  output logic        rs_has_one_slot,
  output logic [3:0]  rs_count
);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d, rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
  logic [3:0]  opcode_q [DEPTH], opcode_d [DEPTH];
  logic [2:0]  alu_op_q [DEPTH], alu_op_d [DEPTH];
  logic [4:0]  tag_a_q  [DEPTH], tag_a_d  [DEPTH];
  logic [4:0]  tag_b_q  [DEPTH], tag_b_d  [DEPTH];
  logic [4:0]  dest_q   [DEPTH], dest_d   [DEPTH];
  logic [15:0] data_a_q [DEPTH], data_a_d [DEPTH];
  logic [15:0] data_b_q [DEPTH], data_b_d [DEPTH];
  logic [15:0] imm_q    [DEPTH], imm_d    [DEPTH];
  logic [15:0] pc_q     [DEPTH], pc_d     [DEPTH];

  logic        iv_q, iv_d;
  logic [3:0]  i_opcode_q, i_opcode_d;
  logic [2:0]  i_alu_op_q, i_alu_op_d;
  logic [15:0] i_data_a_q, i_data_a_d, i_data_b_q, i_data_b_d;
  logic [15:0] i_imm_q, i_imm_d, i_pc_q, i_pc_d;
  logic [4:0]  i_dest_q, i_dest_d;

  logic          f1_found, f2_found, sel_found, issue_load;
  logic [IW-1:0] f1_idx, f2_idx, sel_idx, wr2_idx;
  logic          wr1_en, wr2_en;
  logic [16:0]   op_1a, op_1b, op_2a, op_2b;
  logic [3:0]    cnt;

  // Operand capture at dispatch: {ready, data}; CDB 1 has priority over CDB 2.
  function automatic logic [16:0] resolve(input logic v, input logic [4:0] tag,
                                          input logic [15:0] data,
                                          input logic c1v, input logic [4:0] c1t,
                                          input logic [15:0] c1d,
                                          input logic c2v, input logic [4:0] c2t,
                                          input logic [15:0] c2d);
    if (v)                     return {1'b1, data};
    else if (c1v && c1t == tag) return {1'b1, c1d};
    else if (c2v && c2t == tag) return {1'b1, c2d};
    else                       return {1'b0, data};
  endfunction

  assign op_1a = resolve(rs_valid_a_1, rs_tag_a_1, rs_data_a_1, cdb_valid_1, cdb_tag_1,
                         cdb_data_1, cdb_valid_2, cdb_tag_2, cdb_data_2);
  assign op_1b = resolve(rs_valid_b_1, rs_tag_b_1, rs_data_b_1, cdb_valid_1, cdb_tag_1,
                         cdb_data_1, cdb_valid_2, cdb_tag_2, cdb_data_2);
  assign op_2a = resolve(rs_valid_a_2, rs_tag_a_2, rs_data_a_2, cdb_valid_1, cdb_tag_1,
                         cdb_data_1, cdb_valid_2, cdb_tag_2, cdb_data_2);
  assign op_2b = resolve(rs_valid_b_2, rs_tag_b_2, rs_data_b_2, cdb_valid_1, cdb_tag_1,
                         cdb_data_1, cdb_valid_2, cdb_tag_2, cdb_data_2);

  // Free and ready searches use registered busy bits, so an entry issued this cycle
  // cannot be refilled until the next one.
  always_comb begin
    f1_found  = 1'b0;
    f1_idx    = '0;
    f2_found  = 1'b0;
    f2_idx    = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    cnt       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + {3'b000, busy_q[i]};
      if (!busy_q[i]) begin
        if (!f1_found) begin
          f1_found = 1'b1;
          f1_idx   = IW'(i);
        end else if (!f2_found) begin
          f2_found = 1'b1;
          f2_idx   = IW'(i);
        end
      end else if (rdy_a_q[i] && rdy_b_q[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign issue_load = !iv_q || issue_ready;
  assign wr1_en     = rs_valid_1 && f1_found;
  assign wr2_en     = rs_valid_2 && (rs_valid_1 ? f2_found : f1_found);
  assign wr2_idx    = rs_valid_1 ? f2_idx : f1_idx;

  always_comb begin
    busy_d     = busy_q;
    rdy_a_d    = rdy_a_q;
    rdy_b_d    = rdy_b_q;
    opcode_d   = opcode_q;
    alu_op_d   = alu_op_q;
    tag_a_d    = tag_a_q;
    tag_b_d    = tag_b_q;
    dest_d     = dest_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    iv_d       = iv_q;
    i_opcode_d = i_opcode_q;
    i_alu_op_d = i_alu_op_q;
    i_data_a_d = i_data_a_q;
    i_data_b_d = i_data_b_q;
    i_imm_d    = i_imm_q;
    i_pc_d     = i_pc_q;
    i_dest_d   = i_dest_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && !rdy_a_q[i]) begin
        if (cdb_valid_1 && cdb_tag_1 == tag_a_q[i]) begin
          rdy_a_d[i] = 1'b1; data_a_d[i] = cdb_data_1;
        end else if (cdb_valid_2 && cdb_tag_2 == tag_a_q[i]) begin
          rdy_a_d[i] = 1'b1; data_a_d[i] = cdb_data_2;
        end
      end
      if (busy_q[i] && !rdy_b_q[i]) begin
        if (cdb_valid_1 && cdb_tag_1 == tag_b_q[i]) begin
          rdy_b_d[i] = 1'b1; data_b_d[i] = cdb_data_1;
        end else if (cdb_valid_2 && cdb_tag_2 == tag_b_q[i]) begin
          rdy_b_d[i] = 1'b1; data_b_d[i] = cdb_data_2;
        end
      end
    end
    // issue_valid/issue_ready: a payload transfers on a rising edge where both are 1;
    // while valid is 1 and ready is 0 the payload holds and nothing is selected.
    if (issue_load) begin
      iv_d = sel_found;
      if (sel_found) begin
        i_opcode_d      = opcode_q[sel_idx];
        i_alu_op_d      = alu_op_q[sel_idx];
        i_data_a_d      = data_a_q[sel_idx];
        i_data_b_d      = data_b_q[sel_idx];
        i_imm_d         = imm_q[sel_idx];
        i_pc_d          = pc_q[sel_idx];
        i_dest_d        = dest_q[sel_idx];
        busy_d[sel_idx] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (wr1_en && f1_idx == IW'(i)) begin
        busy_d[i]   = 1'b1;          opcode_d[i] = rs_opcode_1;
        alu_op_d[i] = rs_alu_op_1;   tag_a_d[i]  = rs_tag_a_1;
        tag_b_d[i]  = rs_tag_b_1;    dest_d[i]   = rs_rrf_dest_1;
        imm_d[i]    = rs_imm_1;      pc_d[i]     = rs_pc_1;
        rdy_a_d[i]  = op_1a[16];     data_a_d[i] = op_1a[15:0];
        rdy_b_d[i]  = op_1b[16];     data_b_d[i] = op_1b[15:0];
      end else if (wr2_en && wr2_idx == IW'(i)) begin
        busy_d[i]   = 1'b1;          opcode_d[i] = rs_opcode_2;
        alu_op_d[i] = rs_alu_op_2;   tag_a_d[i]  = rs_tag_a_2;
        tag_b_d[i]  = rs_tag_b_2;    dest_d[i]   = rs_rrf_dest_2;
        imm_d[i]    = rs_imm_2;      pc_d[i]     = rs_pc_2;
        rdy_a_d[i]  = op_2a[16];     data_a_d[i] = op_2a[15:0];
        rdy_b_d[i]  = op_2b[16];     data_b_d[i] = op_2b[15:0];
      end
    end
    if (flush) begin
      busy_d = '0;
      iv_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      rdy_a_q    <= '0;
      rdy_b_q    <= '0;
      iv_q       <= 1'b0;
      i_opcode_q <= '0;
      i_alu_op_q <= '0;
      i_data_a_q <= '0;
      i_data_b_q <= '0;
      i_imm_q    <= '0;
      i_pc_q     <= '0;
      i_dest_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i] <= '0; alu_op_q[i] <= '0; tag_a_q[i] <= '0; tag_b_q[i] <= '0;
        dest_q[i]   <= '0; data_a_q[i] <= '0; data_b_q[i] <= '0;
        imm_q[i]    <= '0; pc_q[i]     <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      rdy_a_q    <= rdy_a_d;
      rdy_b_q    <= rdy_b_d;
      iv_q       <= iv_d;
      i_opcode_q <= i_opcode_d;
      i_alu_op_q <= i_alu_op_d;
      i_data_a_q <= i_data_a_d;
      i_data_b_q <= i_data_b_d;
      i_imm_q    <= i_imm_d;
      i_pc_q     <= i_pc_d;
      i_dest_q   <= i_dest_d;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i] <= opcode_d[i]; alu_op_q[i] <= alu_op_d[i];
        tag_a_q[i]  <= tag_a_d[i];  tag_b_q[i]  <= tag_b_d[i];
        dest_q[i]   <= dest_d[i];   data_a_q[i] <= data_a_d[i];
        data_b_q[i] <= data_b_d[i]; imm_q[i]    <= imm_d[i];
        pc_q[i]     <= pc_d[i];
      end
    end
  end

  assign issue_valid     = iv_q;
  assign issue_opcode    = i_opcode_q;
  assign issue_alu_op    = i_alu_op_q;
  assign issue_data_a    = i_data_a_q;
  assign issue_data_b    = i_data_b_q;
  assign issue_imm       = i_imm_q;
  assign issue_pc        = i_pc_q;
  assign issue_rrf_dest  = i_dest_q;
  assign rs_count        = cnt;
  assign rs_full         = (cnt == 4'd8);
  assign rs_has_one_slot = (cnt == 4'd7);
endmodule
